dump_serializer: RTL
====================

# dump_serializer

Byte-level sequencer between the memory dump unit and the UART transmitter. It captures each memory word the dump unit presents and sends it to the UART as `DATA_SIZE/8` bytes, least-significant byte first. It then returns a one-cycle ready pulse so the dump unit advances to the next address. When the dump unit signals end of dump, the block appends a terminator byte and counts the words sent.

## Interface
Parameters:
- `DATA_SIZE`, 32, memory word width; must be a multiple of `BYTE_SIZE`
- `BYTE_SIZE`, 8, UART character width
- `COUNT_SIZE`, 12, width of the sent-word counter
- `END_BYTE`, 8'h0A, terminator character sent after the last word

Ports:
- `i_clock`  in  1  system clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_valid`  in  1  word-valid level from the dump unit; only its rising edge is used
- `i_data`  in  `DATA_SIZE`  memory read data for the current dump address; stable while `i_valid` is high
- `i_end`  in  1  end-of-dump level from the dump unit; only its rising edge is used
- `i_tx_done`  in  1  one-cycle pulse from the UART when a character has finished
- `o_tx_start`  out  1  one-cycle pulse that launches one UART character
- `o_tx_data`  out  `BYTE_SIZE`  character to send; valid while `o_tx_start` is high
- `o_ready`  out  1  one-cycle pulse: word fully sent, dump unit may fetch the next word
- `o_busy`  out  1  high in every state except IDLE
- `o_word_count`  out  `COUNT_SIZE`  words sent in the current dump
- `o_overrun`  out  1  sticky error flag; cleared only by reset

## Operation
- Edge detection uses registered copies of `i_valid` and `i_end`. A rising edge means `x & ~x_d`.
- States:
  - IDLE
  - START: drive `o_tx_start`
  - WAIT: wait for `i_tx_done`
  - ACK: drive `o_ready`
  - TERM_START: drive `o_tx_start` with the terminator
  - TERM_WAIT: wait for the terminator's `i_tx_done`
- IDLE:
  - On a rising edge of `i_valid`: load `i_data` into the shift register, set the byte index to 0, go to START.
  - On a rising edge of `i_end` alone: go to TERM_START.
  - If both edges occur in the same cycle, the word wins and the end is latched as pending.
- START: assert `o_tx_start` for one cycle with `o_tx_data` = shift[`BYTE_SIZE`-1:0], then go to WAIT.
- WAIT:
  - On `i_tx_done`: shift right by `BYTE_SIZE` and increment the byte index.
  - If the index was the last one (`DATA_SIZE/BYTE_SIZE`-1), go to ACK; otherwise go to START.
- ACK:
  - Assert `o_ready` for one cycle and increment `o_word_count`.
  - If an end is pending, go to TERM_START; otherwise go to IDLE.
- TERM_START: send `END_BYTE`, then go to TERM_WAIT.
- TERM_WAIT: on `i_tx_done`, clear the pending-end flag and go to IDLE.
- Word counter:
  - Cleared on the first word accepted after reset or after a terminator has been sent. A dump with zero words leaves the counter at 0.
  - Wraps modulo 2^`COUNT_SIZE`.
- Ignored events:
  - A rising edge of `i_valid` outside IDLE is dropped and sets `o_overrun`. The transfer in progress is not disturbed.
  - A rising edge of `i_end` in START, WAIT or ACK sets the pending-end flag.
  - `i_tx_done` outside WAIT and TERM_WAIT is ignored.
- Reset mid-operation: the next edge returns the block to IDLE. The UART may still finish its current character; the resulting `i_tx_done` falls in IDLE and is ignored.

## Timing
- Reset values:
  - `o_tx_start`=0, `o_tx_data`=0, `o_ready`=0, `o_busy`=0, `o_word_count`=0, `o_overrun`=0
  - shift register, byte index, edge registers and pending-end flag all 0
- All outputs are registered.
- Latencies:
  - `i_valid` rises during cycle n: `o_tx_start` is high in cycle n+1 with byte 0.
  - `i_tx_done` is high in cycle k: the next `o_tx_start` is high in cycle k+1.
  - The final byte's `i_tx_done` in cycle k: `o_ready` is high in cycle k+1.
  - Terminator after ACK: `o_tx_start` with `END_BYTE` is high in cycle k+2.
- `o_tx_start` and `o_ready` are never high in the same cycle.
- Each character produces exactly one `o_tx_start` pulse.

## Structure
- Shared package `iagc_pkg` holds:
  - serializer state encoding (3 bits)
  - `END_BYTE` default
  - the IAGC status constants already shared with the dump unit
- Sub-module `edge_detect` (1-bit registered rising-edge detector with synchronous reset), instantiated twice: for `i_valid` and `i_end`.
- Everything else (FSM, shift register, counters) lives in one module.

## Test plan
- Single word: `i_data`=32'hDDCCBBAA, one `i_valid` pulse, UART model returns `i_tx_done` 5 cycles after each start.
  - Required: characters AA, BB, CC, DD in order; one `o_ready` one cycle after the 4th done; `o_word_count`=1.
- Three words, then `i_end`.
  - Required: 12 data characters followed by 0A; `o_word_count`=3; `o_busy` low after the terminator's done.
- `i_end` rising while in WAIT of the last word.
  - Required: `o_ready`, then 0A; no characters dropped.
- Second `i_valid` edge during WAIT.
  - Required: `o_overrun`=1 and stays 1; the current word completes unchanged.
- `i_reset` pulsed during byte 2's WAIT, followed by a stray `i_tx_done`.
  - Required: all outputs at reset values, no `o_tx_start`, state remains IDLE.
- `COUNT_SIZE`=2, five words.
  - Required: `o_word_count` sequence 1, 2, 3, 0, 1; a new dump after the terminator restarts at 1.

Source files
------------

// File: rtl/iagc_pkg.sv
// Definitions shared by the IAGC dump path: serializer state encoding,
// default terminator character and the status codes shared with the dump unit.
package iagc_pkg;

  typedef enum logic [2:0] {
    SER_IDLE       = 3'd0,
    SER_START      = 3'd1,
    SER_WAIT       = 3'd2,
    SER_ACK        = 3'd3,
    SER_TERM_START = 3'd4,
    SER_TERM_WAIT  = 3'd5
  } ser_state_t;

  localparam logic [7:0] END_BYTE_DEFAULT = 8'h0A;

  typedef enum logic [1:0] {
    IAGC_STATUS_IDLE    = 2'd0,
    IAGC_STATUS_DUMPING = 2'd1,
    IAGC_STATUS_DONE    = 2'd2,
    IAGC_STATUS_ERROR   = 2'd3
  } iagc_status_t;

  // Number of UART characters needed for one memory word.
  function automatic int bytes_per_word(input int data_size, input int byte_size);
    return data_size / byte_size;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One-bit registered rising-edge detector; output is combinational from the
// live input against its registered copy.
module edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_signal,
  output logic o_rise
);

  logic signal_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) signal_d <= 1'b0;
    else         signal_d <= i_signal;
  end

  assign o_rise = i_signal & ~signal_d;

endmodule

// File: rtl/dump_serializer.sv
// Splits each dumped memory word into UART characters (LSB first), handshakes
// the dump unit with a ready pulse and closes a dump with a terminator byte.
module dump_serializer
  import iagc_pkg::*;
#(
  parameter int                   DATA_SIZE  = 32,
  parameter int                   BYTE_SIZE  = 8,
  parameter int                   COUNT_SIZE = 12,
  parameter logic [BYTE_SIZE-1:0] END_BYTE   = BYTE_SIZE'(END_BYTE_DEFAULT)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [DATA_SIZE-1:0]  i_data,
  input  logic                  i_end,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [BYTE_SIZE-1:0]  o_tx_data,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic [COUNT_SIZE-1:0] o_word_count,
  output logic                  o_overrun
);

  localparam int NBYTES = bytes_per_word(DATA_SIZE, BYTE_SIZE);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ser_state_t           state, state_next;
  logic [DATA_SIZE-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     byte_idx;
  logic                 end_pending;
  logic                 count_restart;

  logic valid_rise, end_rise;
  logic load, shift_en, set_pend, clr_pend, overrun_set, term_from_idle;
  logic start_next;
  logic [BYTE_SIZE-1:0] tx_data_next;

  edge_detect u_valid_edge (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_signal (i_valid),
    .o_rise   (valid_rise)
  );

  edge_detect u_end_edge (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_signal (i_end),
    .o_rise   (end_rise)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= SER_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next     = state;
    load           = 1'b0;
    shift_en       = 1'b0;
    set_pend       = 1'b0;
    clr_pend       = 1'b0;
    term_from_idle = 1'b0;
    overrun_set    = valid_rise && (state != SER_IDLE);
    case (state)
      SER_IDLE: begin
        if (valid_rise) begin
          load       = 1'b1;
          set_pend   = end_rise;
          state_next = SER_START;
        end else if (end_rise) begin
          term_from_idle = 1'b1;
          state_next     = SER_TERM_START;
        end
      end
      SER_START: begin
        set_pend   = end_rise;
        state_next = SER_WAIT;
      end
      SER_WAIT: begin
        set_pend = end_rise;
        if (i_tx_done) begin
          shift_en   = 1'b1;
          state_next = (byte_idx == LAST_IDX) ? SER_ACK : SER_START;
        end
      end
      SER_ACK: begin
        // An end arriving in this very cycle must not be lost on the way to IDLE.
        set_pend   = end_rise;
        state_next = (end_pending || end_rise) ? SER_TERM_START : SER_IDLE;
      end
      SER_TERM_START: state_next = SER_TERM_WAIT;
      SER_TERM_WAIT: begin
        if (i_tx_done) begin
          clr_pend   = 1'b1;
          state_next = SER_IDLE;
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  always_comb begin
    shift_next = shift_reg;
    if (load)          shift_next = i_data;
    else if (shift_en) shift_next = shift_reg >> BYTE_SIZE;
    start_next   = (state_next == SER_START) || (state_next == SER_TERM_START);
    tx_data_next = (state_next == SER_TERM_START) ? END_BYTE : shift_next[BYTE_SIZE-1:0];
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_reg     <= '0;
      byte_idx      <= '0;
      end_pending   <= 1'b0;
      count_restart <= 1'b1;
      o_tx_start    <= 1'b0;
      o_tx_data     <= '0;
      o_ready       <= 1'b0;
      o_busy        <= 1'b0;
      o_word_count  <= '0;
      o_overrun     <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      if (load)          byte_idx <= '0;
      else if (shift_en) byte_idx <= byte_idx + IDX_W'(1);
      if (clr_pend)      end_pending <= 1'b0;
      else if (set_pend) end_pending <= 1'b1;
      o_overrun  <= o_overrun | overrun_set;
      o_tx_start <= start_next;
      if (start_next) o_tx_data <= tx_data_next;
      o_ready <= (state_next == SER_ACK);
      o_busy  <= (state_next != SER_IDLE);
      if ((load || term_from_idle) && count_restart) begin
        o_word_count  <= '0;
        count_restart <= 1'b0;
      end else if (state_next == SER_ACK) begin
        o_word_count <= o_word_count + COUNT_SIZE'(1);
      end
      if (clr_pend) count_restart <= 1'b1;
    end
  end

endmodule
